mem_bus_arbiter: RTL and testbench

- Single-port memory bus arbiter for the 6502 core.
- Shares one 16-bit address / 8-bit data memory port between three requesters:
  - instruction fetcher: reads only, PC/operand stream
  - execute stage: load/store
  - OAM DMA engine: burst copy that halts the CPU
- Arbitrates every cycle, routes read data back to the owning requester, supports a locked DMA burst, and guarantees fetch forward progress with a starvation counter.

---
 rtl/mem_bus_arbiter.sv | 109 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter shared by the 6502 fetcher, execute stage and OAM DMA.
// Combinational grant/mux each cycle; registered read-return routing, DMA lock FSM and fetch starvation counter.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  input  logic                  e_req,
  input  logic                  e_we,
  input  logic [ADDR_WIDTH-1:0] e_addr,
  input  logic [DATA_WIDTH-1:0] e_wdata,
  output logic                  e_gnt,
  output logic                  e_rvalid,
  input  logic                  d_req,
  input  logic                  d_lock,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  cpu_halt,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t     state;
  logic [3:0] starve;
  logic       starved;

  assign starved = (starve == 4'(STARVE_LIMIT));
  assign rdata   = mem_rdata;

  // A starved fetcher jumps ahead of execute, but DMA always wins
  always_comb begin
    f_gnt = 1'b0;
    e_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset_n) begin
      if (state == LOCKED)     d_gnt = d_req;
      else if (d_req)          d_gnt = 1'b1;
      else if (starved && f_req) f_gnt = 1'b1;
      else if (e_req)          e_gnt = 1'b1;
      else if (f_req)          f_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = f_gnt | e_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (e_gnt) begin
      mem_we    = e_we;
      mem_addr  = e_addr;
      mem_wdata = e_wdata;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= UNLOCKED;
      starve   <= '0;
      cpu_halt <= 1'b0;
      f_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
      e_rvalid <= e_gnt & ~e_we;
      d_rvalid <= d_gnt & ~d_we;
      case (state)
        UNLOCKED: begin
          if (d_gnt && d_lock) begin
            state    <= LOCKED;
            cpu_halt <= 1'b1;
          end
          if (f_gnt || !f_req) starve <= '0;
          else if (!starved)   starve <= starve + 4'd1;
        end
        LOCKED: begin
          if (!d_lock) begin
            state    <= UNLOCKED;
            cpu_halt <= 1'b0;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared against a priority-list reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic          e_req, e_we, e_gnt, e_rvalid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          d_req, d_lock, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] rdata, mem_rdata;
  logic          cpu_halt, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner codes 0 none, 1 fetch, 2 execute, 3 DMA
  bit m_locked = 1'b0;
  int m_starve = 0;
  int m_pend   = 0;
  int m_last   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid),
    .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .cpu_halt(cpu_halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic int winner();
    if (!reset_n) return 0;
    if (d_req) return 3;
    if (m_locked) return 0;
    if (m_starve >= int'(LIM)) begin
      if (f_req) return 1;
      if (e_req) return 2;
    end else begin
      if (e_req) return 2;
      if (f_req) return 1;
    end
    return 0;
  endfunction

  task automatic next_cycle();
    int w;
    @(posedge clk);
    w = winner();
    if (!reset_n) begin
      m_locked = 1'b0; m_starve = 0; m_pend = 0; m_last = 0;
    end else begin
      m_pend = (w == 1) ? 1 : (w == 2 && !e_we) ? 2 : (w == 3 && !d_we) ? 3 : 0;
      if (!m_locked) m_starve = (f_req && w != 1) ? ((m_starve < int'(LIM)) ? m_starve + 1 : m_starve) : 0;
      if (!m_locked && w == 3 && d_lock) m_locked = 1'b1;
      else if (m_locked && !d_lock)      m_locked = 1'b0;
      m_last = w;
    end
    #1;
  endtask

  task automatic clear_inputs();
    f_req = 0; e_req = 0; e_we = 0; d_req = 0; d_lock = 0; d_we = 0;
    f_addr = '0; e_addr = '0; e_wdata = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    reset_n = 0; mem_rdata = '0;
    clear_inputs();
    f_req = 1; e_req = 1; d_req = 1; d_lock = 1; d_we = 1;
    f_addr = 16'h1234; e_addr = 16'h4321; d_addr = 16'hBEEF; d_wdata = 8'hAA;
    next_cycle(); next_cycle();
    @(negedge clk);
    n_tests++;
    if ({f_gnt, e_gnt, d_gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_grants got=%b exp=000", {f_gnt, e_gnt, d_gnt}); end
    n_tests++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem got en=%b we=%b addr=%h wdata=%h exp all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    n_tests++;
    if ({f_rvalid, e_rvalid, d_rvalid, cpu_halt} !== 4'b0000) begin n_fail++; $display("FAIL reset_regs got rvalid/halt=%b exp=0000", {f_rvalid, e_rvalid, d_rvalid, cpu_halt}); end
    clear_inputs();
    next_cycle();
    reset_n = 1;
    idle(1);
  endtask

  task automatic test_fetch_only();
    f_req = 1; f_addr = 16'h8000;
    @(negedge clk);
    n_tests++;
    if ({f_gnt, e_gnt, d_gnt, mem_en, mem_we} !== 5'b10010) begin n_fail++; $display("FAIL fetch_gnt got gnt/en/we=%b exp=10010", {f_gnt, e_gnt, d_gnt, mem_en, mem_we}); end
    n_tests++;
    if (mem_addr !== 16'h8000) begin n_fail++; $display("FAIL fetch_addr got=%h exp=8000", mem_addr); end
    next_cycle();
    f_req = 0; mem_rdata = 8'hA9;
    @(negedge clk);
    n_tests++;
    if ({f_rvalid, e_rvalid, d_rvalid} !== 3'b100) begin n_fail++; $display("FAIL fetch_rvalid got=%b exp=100", {f_rvalid, e_rvalid, d_rvalid}); end
    n_tests++;
    if (rdata !== 8'hA9) begin n_fail++; $display("FAIL fetch_rdata got=%h exp=a9", rdata); end
    idle(1);
  endtask

  task automatic test_contention();
    logic [2:0] exp_g;
    logic       prev_e = 1'b0;
    f_req = 1; f_addr = 16'h8001; e_req = 1; e_we = 0; e_addr = 16'h0300;
    for (int i = 0; i < 10; i++) begin
      exp_g = (i % 5 == 4) ? 3'b100 : 3'b010;
      @(negedge clk);
      n_tests++;
      if ({f_gnt, e_gnt, d_gnt} !== exp_g) begin n_fail++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, {f_gnt, e_gnt, d_gnt}, exp_g); end
      n_tests++;
      if (e_rvalid !== prev_e) begin n_fail++; $display("FAIL contention_e_rvalid[%0d] got=%b exp=%b", i, e_rvalid, prev_e); end
      prev_e = exp_g[1];
      next_cycle();
    end
    idle(1);
  endtask

  task automatic test_exec_write();
    e_req = 1; e_we = 1; e_addr = 16'h0200; e_wdata = 8'h55;
    @(negedge clk);
    n_tests++;
    if ({e_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 16'h0200, 8'h55}) begin
      n_fail++; $display("FAIL exec_write got gnt=%b en=%b we=%b addr=%h wdata=%h exp 1 1 1 0200 55", e_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if ({f_rvalid, e_rvalid, d_rvalid} !== 3'b000) begin n_fail++; $display("FAIL exec_write_rvalid got=%b exp=000", {f_rvalid, e_rvalid, d_rvalid}); end
    idle(1);
  endtask

  task automatic test_dma_lock();
    bit         dreq [6] = '{1, 1, 0, 1, 1, 0};
    bit         dlk  [6] = '{1, 1, 1, 1, 0, 0};
    logic [2:0] eg   [6] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b010};
    bit         hlt  [6] = '{0, 1, 1, 1, 1, 0};
    bit         drv  [6] = '{0, 1, 1, 0, 1, 1};
    f_req = 1; f_addr = 16'h8100; e_req = 1; e_we = 0; e_addr = 16'h0010; d_we = 0;
    for (int i = 0; i < 6; i++) begin
      d_req = dreq[i]; d_lock = dlk[i]; d_addr = 16'h2000 + 16'(i);
      @(negedge clk);
      n_tests++;
      if ({f_gnt, e_gnt, d_gnt, mem_en} !== {eg[i], |eg[i]}) begin n_fail++; $display("FAIL dma_gnt[%0d] got gnt/en=%b exp=%b", i, {f_gnt, e_gnt, d_gnt, mem_en}, {eg[i], |eg[i]}); end
      n_tests++;
      if (cpu_halt !== hlt[i]) begin n_fail++; $display("FAIL dma_halt[%0d] got=%b exp=%b", i, cpu_halt, hlt[i]); end
      n_tests++;
      if (d_rvalid !== drv[i]) begin n_fail++; $display("FAIL dma_rvalid[%0d] got=%b exp=%b", i, d_rvalid, drv[i]); end
      next_cycle();
    end
    idle(1);
  endtask

  task automatic test_priority();
    d_req = 1; d_lock = 0; d_we = 0; d_addr = 16'h4000; e_req = 1; e_addr = 16'h0050; f_req = 1; f_addr = 16'h8200;
    @(negedge clk);
    n_tests++;
    if ({f_gnt, e_gnt, d_gnt, mem_addr} !== {3'b001, 16'h4000}) begin n_fail++; $display("FAIL prio_dma got gnt=%b addr=%h exp 001 4000", {f_gnt, e_gnt, d_gnt}, mem_addr); end
    next_cycle();
    d_req = 0;
    @(negedge clk);
    n_tests++;
    if ({f_gnt, e_gnt, d_gnt, mem_addr} !== {3'b010, 16'h0050}) begin n_fail++; $display("FAIL prio_exec got gnt=%b addr=%h exp 010 0050", {f_gnt, e_gnt, d_gnt}, mem_addr); end
    n_tests++;
    if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL prio_d_rvalid got=%b exp=1", d_rvalid); end
    idle(1);
  endtask

  task automatic test_reset_mid_lock();
    d_req = 1; d_lock = 1; d_we = 0; d_addr = 16'h3000;
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({d_gnt, cpu_halt} !== 2'b11) begin n_fail++; $display("FAIL rml_locked got gnt/halt=%b exp=11", {d_gnt, cpu_halt}); end
    next_cycle();
    reset_n = 0;
    @(negedge clk);
    n_tests++;
    if ({f_gnt, e_gnt, d_gnt, mem_en} !== 4'b0000) begin n_fail++; $display("FAIL rml_reset_gnt got=%b exp=0000", {f_gnt, e_gnt, d_gnt, mem_en}); end
    next_cycle();
    reset_n = 1; clear_inputs(); f_req = 1; f_addr = 16'h8010;
    @(negedge clk);
    n_tests++;
    if ({cpu_halt, f_rvalid, e_rvalid, d_rvalid} !== 4'b0000) begin n_fail++; $display("FAIL rml_cleared got halt/rvalid=%b exp=0000", {cpu_halt, f_rvalid, e_rvalid, d_rvalid}); end
    n_tests++;
    if ({f_gnt, mem_addr} !== {1'b1, 16'h8010}) begin n_fail++; $display("FAIL rml_fetch got gnt=%b addr=%h exp 1 8010", f_gnt, mem_addr); end
    next_cycle();
    f_req = 0; mem_rdata = 8'h3C;
    @(negedge clk);
    n_tests++;
    if ({f_rvalid, rdata} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL rml_fetch_data got rvalid=%b rdata=%h exp 1 3c", f_rvalid, rdata); end
    idle(1);
  endtask

  task automatic test_random();
    int                 w;
    logic [AW+DW+1:0]   exp_mem;
    for (int i = 0; i < 400; i++) begin
      if (!(f_req && m_last != 1)) begin f_req = ($urandom_range(0, 3) != 0); f_addr = AW'($urandom); end
      if (!(e_req && m_last != 2)) begin
        e_req = ($urandom_range(0, 2) != 0); e_we = $urandom_range(0, 1);
        e_addr = AW'($urandom); e_wdata = DW'($urandom);
      end
      if (!(d_req && m_last != 3)) begin
        d_req = ($urandom_range(0, 4) == 0); d_we = $urandom_range(0, 1);
        d_addr = AW'($urandom); d_wdata = DW'($urandom);
        d_lock = ($urandom_range(0, 3) != 0);
      end
      mem_rdata = DW'($urandom);
      @(negedge clk);
      w = winner();
      case (w)
        1:       exp_mem = {1'b1, 1'b0, f_addr, {DW{1'b0}}};
        2:       exp_mem = {1'b1, e_we, e_addr, e_wdata};
        3:       exp_mem = {1'b1, d_we, d_addr, d_wdata};
        default: exp_mem = '0;
      endcase
      n_tests++;
      if ({f_gnt, e_gnt, d_gnt} !== {w == 1, w == 2, w == 3}) begin n_fail++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, {f_gnt, e_gnt, d_gnt}, {w == 1, w == 2, w == 3}); end
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== exp_mem) begin n_fail++; $display("FAIL rand_mem[%0d] got=%h exp=%h", i, {mem_en, mem_we, mem_addr, mem_wdata}, exp_mem); end
      n_tests++;
      if ({f_rvalid, e_rvalid, d_rvalid} !== {m_pend == 1, m_pend == 2, m_pend == 3}) begin n_fail++; $display("FAIL rand_rvalid[%0d] got=%b exp owner=%0d", i, {f_rvalid, e_rvalid, d_rvalid}, m_pend); end
      n_tests++;
      if (cpu_halt !== m_locked) begin n_fail++; $display("FAIL rand_halt[%0d] got=%b exp=%b", i, cpu_halt, m_locked); end
      n_tests++;
      if (rdata !== mem_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, rdata, mem_rdata); end
      next_cycle();
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_contention();
    test_exec_write();
    test_dma_lock();
    test_priority();
    test_reset_mid_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
